// File: rtl/benes_select_loader.sv
// Loads per-stage Benes module/slot selects into a shadow bank and swaps them into the active bank on commit.
// Commit-to-active is three edges when the network is idle; commands are refused (o_cmd_ready=0, o_err) while a commit waits or applies.
package benes_select_loader_pkg;
  localparam int          STAGE_NUM        = 9;
  localparam logic [7:0]  COMMAND_SET_RING = 8'd29;

  typedef struct packed {
    logic        valid;
    logic [7:0]  command;
    logic [31:0] data0;
    logic [31:0] data1;
  } cmd_data_t;
endpackage

module benes_select_loader
  import benes_select_loader_pkg::*;
#(
  parameter int         STAGES  = STAGE_NUM,
  parameter int         SEL_W   = 16,
  parameter logic [7:0] CMD_CFG = COMMAND_SET_RING
) (
  input  logic                    clk,
  input  logic                    rst,
  input  cmd_data_t               i_cmd,
  input  logic                    i_net_busy,
  output logic                    o_cmd_ready,
  output logic [STAGES*SEL_W-1:0] o_module_select,
  output logic [STAGES*SEL_W-1:0] o_slot_select,
  output logic                    o_cfg_valid,
  output logic                    o_cfg_update,
  output logic                    o_err
);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_APPLY} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [STAGES*SEL_W-1:0] r_shadow_mod;
  logic [STAGES*SEL_W-1:0] r_shadow_slot;
  logic [STAGES*SEL_W-1:0] r_act_mod;
  logic [STAGES*SEL_W-1:0] r_act_slot;
  logic [STAGES-1:0]       r_mask;
  logic                    r_cfg_valid;
  logic                    r_cfg_update;
  logic                    r_err;

  logic                    w_cfg_cmd;
  logic                    w_commit;
  logic [31:0]             w_stage;
  logic                    w_stage_ok;
  logic [SEL_W-1:0]        w_wr_mod;
  logic [SEL_W-1:0]        w_wr_slot;
  logic                    w_wr_en;
  logic                    w_apply;
  logic                    w_err_nxt;
  logic                    w_unused_bits;

  assign w_cfg_cmd     = i_cmd.valid && (i_cmd.command == CMD_CFG);
  assign w_commit      = i_cmd.data0[31];
  assign w_stage       = {28'd0, i_cmd.data0[3:0]};
  assign w_stage_ok    = (w_stage < 32'(STAGES));
  assign w_wr_mod      = SEL_W'(i_cmd.data1[31:16]);
  assign w_wr_slot     = SEL_W'(i_cmd.data1[15:0]);
  assign w_unused_bits = ^i_cmd.data0[30:4];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_apply     = 1'b0;
    w_err_nxt   = 1'b0;
    o_cmd_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        if (w_cfg_cmd) begin
          if (w_commit) begin
            // An incomplete shadow bank must never reach the network.
            if (&r_mask) w_state_nxt = S_PEND;
            else         w_err_nxt   = 1'b1;
          end else if (w_stage_ok) begin
            w_wr_en = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_PEND: begin
        w_err_nxt = w_cfg_cmd;
        if (!i_net_busy) w_state_nxt = S_APPLY;
      end
      S_APPLY: begin
        w_err_nxt   = w_cfg_cmd;
        w_apply     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow_mod  <= '0;
      r_shadow_slot <= '0;
      r_act_mod     <= '0;
      r_act_slot    <= '0;
      r_mask        <= '0;
      r_cfg_valid   <= 1'b0;
      r_cfg_update  <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_err        <= w_err_nxt;
      r_cfg_update <= w_apply;
      if (w_wr_en) begin
        for (int s = 0; s < STAGES; s++) begin
          if (w_stage == 32'(s)) begin
            r_shadow_mod[s*SEL_W +: SEL_W]  <= w_wr_mod;
            r_shadow_slot[s*SEL_W +: SEL_W] <= w_wr_slot;
            r_mask[s]                       <= 1'b1;
          end
        end
      end
      // Shadow is kept after the swap; only the written-mask restarts.
      if (w_apply) begin
        r_act_mod   <= r_shadow_mod;
        r_act_slot  <= r_shadow_slot;
        r_mask      <= '0;
        r_cfg_valid <= 1'b1;
      end
    end
  end

  assign o_module_select = r_act_mod;
  assign o_slot_select   = r_act_slot;
  assign o_cfg_valid     = r_cfg_valid;
  assign o_cfg_update    = r_cfg_update;
  assign o_err           = r_err;

endmodule

// File: tb/tb_benes_select_loader.sv
// Directed and randomized bench for benes_select_loader against a bank-level reference model.
module tb_benes_select_loader;
  import benes_select_loader_pkg::*;

  localparam int         ST  = 9;
  localparam int         SW  = 16;
  localparam int         W   = ST * SW;
  localparam logic [7:0] CFG = 8'd29;

  logic          clk = 1'b0;
  logic          rst;
  cmd_data_t     i_cmd;
  logic          i_net_busy;
  logic          o_cmd_ready;
  logic [W-1:0]  o_module_select;
  logic [W-1:0]  o_slot_select;
  logic          o_cfg_valid;
  logic          o_cfg_update;
  logic          o_err;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_sh_mod [ST];
  logic [15:0] m_sh_slot[ST];
  logic [15:0] m_act_mod [ST];
  logic [15:0] m_act_slot[ST];
  bit          m_mask[ST];
  bit          m_valid;
  bit          m_pend;

  benes_select_loader dut (
    .clk             (clk),
    .rst             (rst),
    .i_cmd           (i_cmd),
    .i_net_busy      (i_net_busy),
    .o_cmd_ready     (o_cmd_ready),
    .o_module_select (o_module_select),
    .o_slot_select   (o_slot_select),
    .o_cfg_valid     (o_cfg_valid),
    .o_cfg_update    (o_cfg_update),
    .o_err           (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] act_packed(input bit slot);
    logic [W-1:0] v;
    v = '0;
    for (int s = 0; s < ST; s++) v[s*SW +: SW] = slot ? m_act_slot[s] : m_act_mod[s];
    return v;
  endfunction

  function automatic bit mask_full();
    bit f;
    f = 1'b1;
    for (int s = 0; s < ST; s++) f = f & m_mask[s];
    return f;
  endfunction

  task automatic m_reset();
    for (int s = 0; s < ST; s++) begin
      m_sh_mod[s] = '0; m_sh_slot[s] = '0; m_act_mod[s] = '0; m_act_slot[s] = '0;
      m_mask[s] = 1'b0;
    end
    m_valid = 1'b0;
    m_pend  = 1'b0;
  endtask

  task automatic chk_active(input string tag);
    chk({tag, "_mod"},   o_module_select, act_packed(1'b0));
    chk({tag, "_slot"},  o_slot_select,   act_packed(1'b1));
    chk({tag, "_valid"}, W'(o_cfg_valid), W'(m_valid));
  endtask

  // One command for one cycle; the model decides the expected error and acceptance.
  task automatic send(input logic [7:0] code, input logic [31:0] d0, input logic [31:0] d1);
    bit exp_err;
    exp_err       = 1'b0;
    i_cmd.valid   = 1'b1;
    i_cmd.command = code;
    i_cmd.data0   = d0;
    i_cmd.data1   = d1;
    @(posedge clk); #1;
    i_cmd.valid = 1'b0;
    if (code == CFG) begin
      if (m_pend) exp_err = 1'b1;
      else if (d0[31]) begin
        if (mask_full()) m_pend = 1'b1;
        else             exp_err = 1'b1;
      end else if (d0[3:0] < ST) begin
        m_sh_mod[d0[3:0]]  = d1[31:16];
        m_sh_slot[d0[3:0]] = d1[15:0];
        m_mask[d0[3:0]]    = 1'b1;
      end else exp_err = 1'b1;
    end
    chk("err", W'(o_err), W'(exp_err));
    chk("ready", W'(o_cmd_ready), W'(!m_pend));
    chk("upd_idle", W'(o_cfg_update), W'(0));
    chk_active("hold");
  endtask

  task automatic full_load(input logic [31:0] base, input bit rnd);
    for (int s = 0; s < ST; s++) send(CFG, 32'(s), rnd ? 32'($urandom) : base + 32'(s));
  endtask

  task automatic commit();
    send(CFG, {1'b1, 31'($urandom)}, 32'($urandom));
  endtask

  // Holds busy for busy_cycles more cycles, then releases it and expects the swap two edges later.
  task automatic finish_commit(input int busy_cycles);
    int n;
    for (int i = 0; i < busy_cycles; i++) begin
      chk("pend_ready", W'(o_cmd_ready), W'(0));
      chk("pend_upd", W'(o_cfg_update), W'(0));
      chk_active("pend");
      @(posedge clk); #1;
    end
    i_net_busy = 1'b0;
    n = 0;
    while (n < 10 && o_cfg_update !== 1'b1) begin
      @(posedge clk); #1;
      n++;
    end
    chk("upd_latency", W'(n), W'(2));
    for (int s = 0; s < ST; s++) begin
      m_act_mod[s] = m_sh_mod[s]; m_act_slot[s] = m_sh_slot[s]; m_mask[s] = 1'b0;
    end
    m_valid = 1'b1;
    m_pend  = 1'b0;
    chk_active("applied");
    chk("ready_after", W'(o_cmd_ready), W'(1));
    @(posedge clk); #1;
    chk("upd_pulse_end", W'(o_cfg_update), W'(0));
  endtask

  initial begin
    int bc;
    int op;
    rst        = 1'b1;
    i_cmd      = '0;
    i_net_busy = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_active("reset");
    chk("reset_ready", W'(o_cmd_ready), W'(1));
    chk("reset_err", W'(o_err), W'(0));
    chk("reset_upd", W'(o_cfg_update), W'(0));

    // Basic full load and idle-network commit.
    full_load(32'h00A0_0050, 1'b0);
    commit();
    finish_commit(0);
    chk("s4_mod",  W'(o_module_select[4*SW +: SW]), W'(16'h00A0));
    chk("s4_slot", W'(o_slot_select[4*SW +: SW]),   W'(16'h0054));

    // Incomplete mask: commit refused, still idle.
    for (int s = 0; s < 8; s++) send(CFG, 32'(s), 32'hBEEF_0000 + 32'(s));
    commit();
    @(posedge clk); #1;
    chk_active("partial_hold");
    chk("partial_ready", W'(o_cmd_ready), W'(1));

    // Out-of-range stage, then a complete reload still commits.
    send(CFG, 32'd9, 32'hDEAD_BEEF);
    full_load(32'h0, 1'b1);
    commit();
    finish_commit(0);

    // Last write to a stage wins.
    send(CFG, 32'd3, 32'h1111_2222);
    send(CFG, 32'd3, 32'h3333_4444);
    for (int s = 0; s < ST; s++) if (s != 3) send(CFG, 32'(s), 32'($urandom));
    commit();
    finish_commit(0);
    chk("s3_mod",  W'(o_module_select[3*SW +: SW]), W'(16'h3333));
    chk("s3_slot", W'(o_slot_select[3*SW +: SW]),   W'(16'h4444));

    // Busy network: commit waits, commands during the wait are refused.
    full_load(32'h0, 1'b1);
    i_net_busy = 1'b1;
    commit();
    for (int i = 0; i < 9; i++) begin
      chk("busy_ready", W'(o_cmd_ready), W'(0));
      @(posedge clk); #1;
    end
    send(CFG, 32'd2, 32'h5555_6666);
    finish_commit(9);

    // Randomized traffic mixed with foreign command codes.
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < 14; j++) begin
        op = int'($urandom_range(0, 9));
        if (op == 0)      send(8'($urandom_range(30, 255)), 32'($urandom), 32'($urandom));
        else if (op == 1) send(CFG, 32'($urandom_range(9, 15)), 32'($urandom));
        else              send(CFG, 32'($urandom_range(0, 8)), 32'($urandom));
      end
      if (!mask_full()) commit();
      full_load(32'h0, 1'b1);
      bc = int'($urandom_range(0, 3));
      i_net_busy = (bc > 0);
      commit();
      finish_commit(bc);
    end

    // Reset while the commit is waiting aborts it.
    full_load(32'h0, 1'b1);
    i_net_busy = 1'b1;
    commit();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst        = 1'b0;
    i_net_busy = 1'b0;
    m_reset();
    chk_active("abort");
    chk("abort_ready", W'(o_cmd_ready), W'(1));
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_upd", W'(o_cfg_update), W'(0));
      @(posedge clk); #1;
    end
    chk_active("abort_late");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/benes_select_loader.md
BENES_SELECT_LOADER -- requirements
Module: benes_select_loader

Interface
REQ-001 SHALL have parameter STAGES, default STAGE_NUM (9), meaning number of Benes stages configured.
REQ-002 SHALL have parameter SEL_W, default 16, meaning width of each per-stage module/slot select word.
REQ-003 SHALL have parameter CMD_CFG, default COMMAND_SET_RING (29), meaning command code accepted by this block.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 i_cmd  input  CommandDataPort (73)  valid, command[7:0], data0[31:0], data1[31:0].
REQ-008 i_net_busy  input  1  high while the downstream Benes interconnect has traffic in flight.
REQ-009 o_cmd_ready  output  1  block can accept a CMD_CFG command this cycle.
REQ-010 o_module_select  output  STAGES*SEL_W  active module selects; stage s occupies bits [s*SEL_W +: SEL_W].
REQ-011 o_slot_select  output  STAGES*SEL_W  active slot selects; same packing.
REQ-012 o_cfg_valid  output  1  active bank holds at least one committed configuration.
REQ-013 o_cfg_update  output  1  one-cycle pulse in the cycle after the active bank changes.
REQ-014 o_err  output  1  one-cycle pulse on a rejected command.

Function
REQ-015 SHALL decode a command only when i_cmd.valid=1 and i_cmd.command==CMD_CFG; other codes are ignored silently.
REQ-016 SHALL treat data0[31]=0 as a WRITE: stage=data0[3:0], module select=data1[31:16], slot select=data1[15:0].
REQ-017 SHALL treat data0[31]=1 as a COMMIT; data0[30:0] and data1 are ignored.
REQ-018 WRITE with stage<STAGES SHALL update the shadow entry on the next clock edge and set that stage's written-mask bit.
REQ-019 WRITE with stage>=STAGES SHALL leave shadow and mask unchanged and pulse o_err next cycle.
REQ-020 Active outputs SHALL never reflect shadow writes before a commit completes.
REQ-021 SHALL implement FSM states IDLE, PEND, APPLY; o_cmd_ready=1 only in IDLE.
REQ-022 IDLE: COMMIT with mask all-ones -> PEND; COMMIT with incomplete mask -> stay IDLE, pulse o_err, mask unchanged.
REQ-023 PEND: stay while i_net_busy=1; go to APPLY in the first cycle i_net_busy=0, sampled at that edge.
REQ-024 APPLY (exactly one cycle): copy all shadow entries to active, clear mask, set o_cfg_valid, then -> IDLE; o_cfg_update pulses in the following cycle.
REQ-025 Minimum COMMIT-to-update latency with i_net_busy=0: COMMIT accepted edge N, PEND at N+1, APPLY at N+2, active outputs change at edge N+3, o_cfg_update high in cycle N+3.
REQ-026 Any CMD_CFG command arriving in PEND or APPLY SHALL be dropped and pulse o_err.
REQ-027 Shadow contents SHALL be retained across commits, so a partial re-write requires re-writing all stages before the next commit, as the mask is cleared.
REQ-028 Repeated WRITE to the same stage before commit SHALL keep the last value.
REQ-029 Active outputs SHALL be registered and stable except at the APPLY edge.

Reset
REQ-030 On rst=1 SHALL go to IDLE and clear shadow, active, and mask to 0; o_cfg_valid=0, o_cfg_update=0, o_err=0, and o_cmd_ready=1 from the first cycle after reset.
REQ-031 rst asserted in PEND or APPLY SHALL abort the commit; the active bank reads 0 after reset.

Verification
REQ-032 Write stages 0..8 with data1=32'h00A0_0050+s, then COMMIT, i_net_busy=0 -> o_cfg_update at N+3; stage 4 module=16'h00A0, slot=16'h0054; o_cfg_valid=1.
REQ-033 Write stages 0..7 only, then COMMIT -> o_err pulse, FSM stays IDLE, outputs unchanged, o_cmd_ready stays 1.
REQ-034 WRITE with stage=9 -> o_err pulse; a subsequent full load and commit still succeeds.
REQ-035 Full load, i_net_busy=1 for 20 cycles, COMMIT -> o_cmd_ready=0 throughout; a WRITE sent during the wait -> o_err pulse; update occurs 2 edges after i_net_busy falls.
REQ-036 Assert rst while in PEND -> all selects 0, o_cfg_valid=0, and no o_cfg_update pulse.
REQ-037 Write stage 3 twice (first 32'h1111_2222, then 32'h3333_4444), fill the rest, then commit -> stage 3 module=16'h3333, slot=16'h4444.
